fade_ifft_ctrl: RTL

- Frame sequencer for the fade IFFT core (AXI-Stream FFT engine followed by the windower).
- On start, writes one configuration word, then streams NFRAMES frames of FFT_N complex bins from an external coefficient RAM into the core's data slave, asserting tlast on the last bin of each frame.
- Watches the core's output stream and event flags, and reports busy/done/error to the host.

---
 rtl/fade_ifft_pkg.sv | 21 ++
 rtl/fade_skid2.sv | 46 ++++
 rtl/fade_ifft_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fade_ifft_pkg.sv
// Shared types and helpers for the fade IFFT frame sequencer.
package fade_ifft_pkg;

  localparam int FFT_N_DEF = 32;
  localparam int IDX_W_DEF = 5;
  localparam int CFG_W_DEF = 16;

  typedef enum logic [1:0] {IDLE, CFG, STREAM, DRAIN} state_t;

  typedef struct packed {
    logic signed [15:0] im;
    logic signed [15:0] re;
  } cplx16_t;

  // Direction bit occupies the LSB, scaling schedule sits above it.
  function automatic logic [CFG_W_DEF-1:0] pack_cfg(input logic [CFG_W_DEF-2:0] scale,
                                                    input logic fwd);
    return {scale, fwd};
  endfunction

endpackage

// File: rtl/fade_skid2.sv
// Two-entry AXI-Stream skid FIFO; absorbs the RAM read latency under backpressure.
module fade_skid2 #(
  parameter int W = 33
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_cnt
);

  logic [W-1:0] r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_cnt;
  logic         w_push;
  logic         w_pop;

  assign w_pop  = (r_cnt != 2'd0) & i_ready;
  assign w_push = i_valid & ((r_cnt != 2'd2) | w_pop);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_push) r_wp <= ~r_wp;
      if (w_pop)  r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end

  // Storage is not reset; the output is gated so an empty buffer always shows zeros.
  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = o_valid ? r_mem[r_rp] : '0;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/fade_ifft_ctrl.sv
// Frame sequencer for the fade IFFT core: config beat, NFRAMES frames from RAM, output frame count.
// Optional output-index checking is enabled by defining FADE_IFFT_CTRL_IDXCHK_EN.
module fade_ifft_ctrl
  import fade_ifft_pkg::*;
#(
  parameter int FFT_N  = FFT_N_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int DATA_W = 32,
  parameter int CFG_W  = CFG_W_DEF,
  parameter int FRM_W  = 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start,
  input  logic [FRM_W-1:0]  nframes,
  input  logic              fwd_inv,
  input  logic [CFG_W-2:0]  scale_sch,
  output logic [CFG_W-1:0]  s_axis_config_tdata,
  output logic              s_axis_config_tvalid,
  input  logic              s_axis_config_tready,
  output logic              ram_rd,
  output logic [IDX_W-1:0]  ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] s_axis_data_tdata,
  output logic              s_axis_data_tvalid,
  input  logic              s_axis_data_tready,
  output logic              s_axis_data_tlast,
  input  logic              m_axis_data_tvalid,
  input  logic              m_axis_data_tready,
  input  logic              m_axis_data_tlast,
  input  logic [7:0]        m_axis_data_tuser,
  input  logic              event_tlast_unexpected,
  input  logic              event_tlast_missing,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_N - 1);

  state_t             r_state;
  logic [FRM_W-1:0]   r_nframes;
  logic [FRM_W-1:0]   r_rd_frm;
  logic [FRM_W-1:0]   r_tx_frm;
  logic [FRM_W-1:0]   r_rx_frm;
  logic [IDX_W-1:0]   r_rd_addr;
  logic               r_rd_done;
  logic               r_inflight;
  logic               r_inflight_last;
  logic [CFG_W-1:0]   r_cfg_tdata;
  logic               r_cfg_tvalid;
  logic               r_done;
  logic               r_err;

  logic [1:0]         w_occ;
  logic [2:0]         w_load;
  logic               w_rd;
  logic               w_s_pop;
  logic               w_m_hs;
  logic               w_idx_err;
  logic [DATA_W-1:0]  w_s_tdata;
  logic               w_s_tvalid;
  logic               w_s_tlast;

  assign w_s_pop = w_s_tvalid & s_axis_data_tready;
  assign w_m_hs  = m_axis_data_tvalid & m_axis_data_tready;

  // Budget counts the beat leaving this cycle, so the buffer refills back-to-back at full rate.
  assign w_load = {1'b0, w_occ} + {2'b0, r_inflight};
  assign w_rd   = (r_state == STREAM) & ~r_rd_done & (w_load <= (3'd1 + {2'b0, w_s_pop}));

  fade_skid2 #(.W(DATA_W + 1)) u_skid (
    .aclk    (aclk),
    .aresetn (aresetn),
    .i_valid (r_inflight),
    .i_data  ({r_inflight_last, ram_dout}),
    .o_valid (w_s_tvalid),
    .i_ready (s_axis_data_tready),
    .o_data  ({w_s_tlast, w_s_tdata}),
    .o_cnt   (w_occ)
  );

`ifdef FADE_IFFT_CTRL_IDXCHK_EN
  logic [IDX_W-1:0] r_exp_idx;
  logic             w_unused_tuser;

  assign w_unused_tuser = &{1'b0, m_axis_data_tuser[7:IDX_W]};
  assign w_idx_err = w_m_hs & ((m_axis_data_tuser[IDX_W-1:0] != r_exp_idx) |
                               (m_axis_data_tlast & (r_exp_idx != LAST_IDX)));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_exp_idx <= '0;
    end else if (r_state == IDLE) begin
      r_exp_idx <= '0;
    end else if (w_m_hs) begin
      r_exp_idx <= m_axis_data_tlast ? '0 : r_exp_idx + 1'b1;
    end
  end
`else
  logic w_unused_tuser;

  assign w_unused_tuser = &{1'b0, m_axis_data_tuser};
  assign w_idx_err      = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state         <= IDLE;
      r_nframes       <= '0;
      r_rd_frm        <= '0;
      r_tx_frm        <= '0;
      r_rx_frm        <= '0;
      r_rd_addr       <= '0;
      r_rd_done       <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_cfg_tdata     <= '0;
      r_cfg_tvalid    <= 1'b0;
      r_done          <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_done          <= 1'b0;
      r_inflight      <= w_rd;
      r_inflight_last <= w_rd & (r_rd_addr == LAST_IDX);

      if (w_rd) begin
        r_rd_addr <= r_rd_addr + 1'b1;
        if (r_rd_addr == LAST_IDX) begin
          r_rd_frm <= r_rd_frm + 1'b1;
          if (r_rd_frm == r_nframes - 1'b1) r_rd_done <= 1'b1;
        end
      end

      if ((r_state != IDLE) & (event_tlast_unexpected | event_tlast_missing | w_idx_err))
        r_err <= 1'b1;

      // Output frames are counted from config completion, overlapping the input stream.
      if (((r_state == STREAM) | (r_state == DRAIN)) & w_m_hs & m_axis_data_tlast)
        r_rx_frm <= r_rx_frm + 1'b1;

      case (r_state)
        IDLE: begin
          if (start && (nframes != '0)) begin
            r_nframes    <= nframes;
            r_err        <= 1'b0;
            r_cfg_tdata  <= pack_cfg(scale_sch, fwd_inv);
            r_cfg_tvalid <= 1'b1;
            r_rd_frm     <= '0;
            r_tx_frm     <= '0;
            r_rx_frm     <= '0;
            r_rd_addr    <= '0;
            r_rd_done    <= 1'b0;
            r_state      <= CFG;
          end
        end
        CFG: begin
          if (s_axis_config_tready) begin
            r_cfg_tvalid <= 1'b0;
            r_state      <= STREAM;
          end
        end
        STREAM: begin
          if (w_s_pop & w_s_tlast) begin
            r_tx_frm <= r_tx_frm + 1'b1;
            if (r_tx_frm == r_nframes - 1'b1) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (r_rx_frm == r_nframes) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_axis_config_tdata  = r_cfg_tdata;
  assign s_axis_config_tvalid = r_cfg_tvalid;
  assign ram_rd               = w_rd;
  assign ram_addr             = r_rd_addr;
  assign s_axis_data_tdata    = w_s_tdata;
  assign s_axis_data_tvalid   = w_s_tvalid;
  assign s_axis_data_tlast    = w_s_tlast;
  assign busy                 = (r_state != IDLE);
  assign done                 = r_done;
  assign err                  = r_err;

endmodule
